// File: rtl/key_sched_writer.sv
// Iterative AES-256 key expansion that writes 15 round keys, one per cycle.
// Define KEY_SCHED_REVERSE_EN to store the keys in decryption order.
module key_sched_writer #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_KEYS   = 15
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [255:0]          key_in,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [3:0] LAST = 4'(NUM_KEYS - 1);

  logic [1:0]            state_q, state_d;
  logic [255:0]          win_q, win_d;
  logic [3:0]            rnd_q, rnd_d;
  logic [7:0]            rcon_q, rcon_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic [31:0]  t_raw;
  logic [31:0]  t;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] nw;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as x^254 (GF inverse, 0 -> 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x14, x15;
    logic [7:0] x30, x60, x120, x240, inv;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x14  = gmul(x12, x2);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    inv  = gmul(x240, x14);
    return inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  always_comb begin
    t_raw = win_q[31:0];
    if (rnd_q[0]) begin
      t = subword(t_raw);
    end else begin
      t = subword({t_raw[23:0], t_raw[31:24]})
        ^ {rcon_q, 24'h000000};
    end
    n0 = win_q[255:224] ^ t;
    n1 = win_q[223:192] ^ n0;
    n2 = win_q[191:160] ^ n1;
    n3 = win_q[159:128] ^ n2;
    nw = {n0, n1, n2, n3};
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    rnd_d     = rnd_q;
    rcon_d    = rcon_q;
    busy_d    = (state_q != S_IDLE);
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start) begin
          win_d   = key_in;
          rnd_d   = 4'd0;
          rcon_d  = 8'h01;
          state_d = S_WRITE;
        end
      end
      (state_q == S_WRITE): begin
        wr_en_d = 1'b1;
`ifdef KEY_SCHED_REVERSE_EN
        wr_addr_d = ADDR_WIDTH'(LAST - rnd_q);
`else
        wr_addr_d = ADDR_WIDTH'(rnd_q);
`endif
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'd0) begin
          wr_data_d = win_q[255:128];
        end else if (rnd_q == 4'd1) begin
          wr_data_d = win_q[127:0];
        end else begin
          wr_data_d = nw;
          win_d     = {win_q[127:0], nw};
          if (!rnd_q[0]) rcon_d = xtime(rcon_q);
        end
        if (rnd_q == LAST) state_d = S_DONE;
      end
      (state_q == S_DONE): begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      win_q     <= '0;
      rnd_q     <= '0;
      rcon_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      rnd_q     <= rnd_d;
      rcon_q    <= rcon_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule
